// File: rtl/sel_mux_arb.sv
// sel_mux_arb: NUM_CH valid/ready channels arbitrated onto one registered output.
// Define SEL_MUX_ASSERT_EN to build in the embedded protocol assertions.
module sel_mux_arb #(
  parameter int WIDTH   = 4,
  parameter int NUM_CH  = 3,
  parameter int RR_MODE = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH*WIDTH-1:0]     ip_data,
  input  logic [NUM_CH-1:0]           ip_valid,
  output logic [NUM_CH-1:0]           ip_ready,
  output logic [WIDTH-1:0]            mux_op,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [$clog2(NUM_CH)-1:0]   grant_id
);

  localparam int GW = $clog2(NUM_CH);

  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       base;
  logic [GW-1:0]       g;
  logic [2*NUM_CH-1:0] vv;
  logic [2*NUM_CH-1:0] rot;
  logic [GW:0]         sum;
  logic                found;
  logic                slot_free;
  logic                load_en;
  logic [WIDTH-1:0]    sel_data;
  logic [GW-1:0]       rr_next;

  // Fixed priority is a scan that always starts at channel 0.
  assign base = (RR_MODE != 0) ? rr_ptr : '0;

  assign slot_free = !op_valid || op_ready;
  assign load_en   = !reset && slot_free && (|ip_valid);

  // Rotate requests so the scan start sits at bit 0, pick the
  // lowest set bit, then map the offset back to a channel index.
  always_comb begin
    vv    = {ip_valid, ip_valid};
    rot   = vv >> base;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, base} + (GW+1)'(k);
      end
    end
    if (sum >= (GW+1)'(NUM_CH)) begin
      sum = sum - (GW+1)'(NUM_CH);
    end
    g = sum[GW-1:0];
  end

  // Data slice of the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g == GW'(i)) begin
        sel_data = ip_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept for the granted channel, only when loading.
  always_comb begin
    ip_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_en && g == GW'(i)) begin
        ip_ready[i] = 1'b1;
      end
    end
  end

  assign rr_next = (g == GW'(NUM_CH-1)) ? '0 : g + GW'(1);

  // Output slot: load on handshake, drop on drain, hold on stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      mux_op   <= '0;
      op_valid <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (load_en) begin
      mux_op   <= sel_data;
      grant_id <= g;
      op_valid <= 1'b1;
      if (RR_MODE != 0) begin
        rr_ptr <= rr_next;
      end
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

`ifdef SEL_MUX_ASSERT_EN
  a_onehot: assert property (
    @(posedge clock) disable iff (reset)
    $onehot0(ip_ready)
  ) else $error("sel_mux_arb: ip_ready not onehot0, channel %0d", g);

  a_stall: assert property (
    @(posedge clock) disable iff (reset)
    op_valid && !op_ready |=>
      $stable(mux_op) && $stable(grant_id) && op_valid
  ) else $error("sel_mux_arb: stall not held, channel %0d", grant_id);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chk
    a_cap: assert property (
      @(posedge clock) disable iff (reset)
      ip_ready[i] |=>
        mux_op == $past(ip_data[i*WIDTH +: WIDTH]) &&
        grant_id == GW'(i)
    ) else $error("sel_mux_arb: bad capture, channel %0d", i);

    a_in: assert property (
      @(posedge clock) disable iff (reset)
      ip_valid[i] && !ip_ready[i] |=>
        ip_valid[i] && $stable(ip_data[i*WIDTH +: WIDTH])
    ) else $error("sel_mux_arb: input dropped, channel %0d", i);
  end
`endif

endmodule
